// File: rtl/axis_stim_player.sv
// Replays a beat table onto a master AXI-Stream port with gaps, multi-pass looping and
// a stop that ends on a packet boundary; one registered output stage, held under back-pressure.
module axis_stim_player #(
  parameter int    DATA_W    = 256,
  parameter int    USER_W    = 128,
  parameter int    DEPTH     = 512,
  parameter string INIT_FILE = "",
  localparam int   KEEP_W    = DATA_W / 8,
  localparam int   ADDR_W    = $clog2(DEPTH),
  localparam int   ENTRY_W   = DATA_W + KEEP_W + USER_W + 8
) (
  input  logic                axis_aclk,
  input  logic                axis_reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [ENTRY_W-1:0]  wr_data,
  input  logic [ADDR_W:0]     cfg_len,
  input  logic [15:0]         cfg_passes,
  input  logic                start,
  input  logic                stop,
  output logic                busy,
  output logic                done,
  output logic [31:0]         beat_cnt,
  output logic [31:0]         pkt_cnt,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [KEEP_W-1:0]   m_axis_tkeep,
  output logic [USER_W-1:0]   m_axis_tuser,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W:0]   LEN_ONE = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;

  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [1:0]         state;
  logic [ADDR_W-1:0]  ptr;
  logic [ADDR_W:0]    len_q;
  logic [15:0]        passes_q;
  logic [15:0]        pass_cnt;
  logic               stop_pend;

  logic [ADDR_W-1:0]  fetch_ptr;
  logic [ADDR_W:0]    fetch_len;
  logic               fetch_wrap;
  logic [ENTRY_W-1:0] entry;
  logic               free;
  logic               accept;
  logic               run_end;
  logic               start_ok;
  logic               load;
  logic               unused_pad;

  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  // Table contents survive reset; writes only land while no run is in flight.
  always_ff @(posedge axis_aclk) begin
    if (wr_en && !busy) mem[wr_addr] <= wr_data;
  end

  // The start cycle fetches entry 0 directly so it is on the bus one cycle after start.
  assign start_ok   = (state == S_IDLE) && start && (cfg_len != '0);
  assign fetch_ptr  = (state == S_IDLE) ? '0 : ptr;
  assign fetch_len  = (state == S_IDLE) ? cfg_len : len_q;
  assign fetch_wrap = ({1'b0, fetch_ptr} == (fetch_len - LEN_ONE));
  assign entry      = mem[fetch_ptr];
  assign unused_pad = ^{entry[7:5], entry[3:1]};

  assign free    = !m_axis_tvalid || m_axis_tready;
  assign accept  = m_axis_tvalid && m_axis_tready;
  assign run_end = ((passes_q != '0) && (pass_cnt == passes_q)) ||
                   (stop_pend && m_axis_tvalid && m_axis_tlast);
  assign load    = start_ok || ((state == S_RUN) && free && !run_end);

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (load) begin
      m_axis_tdata  <= entry[ENTRY_W-1 -: DATA_W];
      m_axis_tkeep  <= entry[USER_W+8 +: KEEP_W];
      m_axis_tuser  <= entry[8 +: USER_W];
      m_axis_tvalid <= entry[4];
      m_axis_tlast  <= entry[0];
    end else if (free) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      len_q     <= '0;
      passes_q  <= '0;
      pass_cnt  <= '0;
      stop_pend <= 1'b0;
      beat_cnt  <= '0;
      pkt_cnt   <= '0;
    end else begin
      if (accept && (beat_cnt != '1)) beat_cnt <= beat_cnt + 32'd1;
      if (accept && m_axis_tlast && (pkt_cnt != '1)) pkt_cnt <= pkt_cnt + 32'd1;

      if (load) begin
        ptr      <= fetch_wrap ? '0 : fetch_ptr + PTR_ONE;
        pass_cnt <= ((state == S_IDLE) ? 16'd0 : pass_cnt) + {15'd0, fetch_wrap};
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            beat_cnt  <= '0;
            pkt_cnt   <= '0;
            stop_pend <= 1'b0;
            len_q     <= cfg_len;
            passes_q  <= cfg_passes;
            state     <= (cfg_len == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (stop) stop_pend <= 1'b1;
          if (free && run_end) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (free) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_stim_player.sv
// Randomized scoreboard bench: a table model predicts the beat stream and counters per run,
// and a negedge monitor checks every accepted beat in order plus AXI hold under back-pressure.
module tb_axis_stim_player;
  localparam int DW = 64;
  localparam int UW = 16;
  localparam int DP = 16;
  localparam int KW = DW / 8;
  localparam int AW = $clog2(DP);
  localparam int EW = DW + KW + UW + 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [EW-1:0] wr_data = '0;
  logic [AW:0]   cfg_len = '0;
  logic [15:0]   cfg_passes = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          busy, done;
  logic [31:0]   beat_cnt, pkt_cnt;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic [UW-1:0] m_tuser;
  logic          m_tvalid, m_tlast;
  logic          m_tready = 1'b1;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    ready_mode = 0;
  int    stop_cyc = -1;
  bit    stopped = 0;
  int    done_cnt = 0;
  int    acc_cnt = 0;
  int    first_acc = -1;
  bit    prev_stall = 0;
  bit    prev_rst = 1;
  beat_t prev_beat = '0;
  logic [EW-1:0] model_mem [DP];
  beat_t exp_q[$];

  axis_stim_player #(.DATA_W(DW), .USER_W(UW), .DEPTH(DP), .INIT_FILE("")) dut (
    .axis_aclk(clk), .axis_reset(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cfg_len(cfg_len), .cfg_passes(cfg_passes), .start(start), .stop(stop),
    .busy(busy), .done(done), .beat_cnt(beat_cnt), .pkt_cnt(pkt_cnt),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // tready: 0 = always ready, 1 = random, 2 = stalled
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ($urandom_range(0, 2) != 0);
        default: m_tready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    beat_t cur;
    beat_t exp_b;
    cur = '{d: m_tdata, k: m_tkeep, u: m_tuser, l: m_tlast};
    if (done) done_cnt++;
    if (prev_stall && !prev_rst) begin
      checks++;
      if (!m_tvalid || cur !== prev_beat) begin
        errors++;
        $display("FAIL hold: got valid=%b %h required valid=1 %h", m_tvalid, cur, prev_beat);
      end
    end
    if (m_tvalid && m_tready) begin
      checks++;
      acc_cnt++;
      if (first_acc < 0) first_acc = cyc;
      if (stopped) begin
        errors++;
        $display("FAIL beat_after_stop: got beat %h required none", cur);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got %h required none", cur);
      end else begin
        exp_b = exp_q.pop_front();
        if (cur !== exp_b) begin
          errors++;
          $display("FAIL beat: got %h required %h", cur, exp_b);
        end
      end
      if (stop_cyc >= 0 && cyc > stop_cyc && m_tlast) stopped = 1;
    end
    prev_stall = m_tvalid && !m_tready;
    prev_beat  = cur;
    prev_rst   = rst;
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [EW-1:0] make_entry(input logic v, input logic l);
    logic [DW-1:0] d;
    d = DW'({$urandom, $urandom});
    return {d, KW'($urandom), UW'($urandom), 3'b000, v, 3'b000, l};
  endfunction

  function automatic beat_t to_beat(input logic [EW-1:0] e);
    beat_t b;
    b.d = e[EW-1 -: DW];
    b.k = e[8+UW +: KW];
    b.u = e[8 +: UW];
    b.l = e[0];
    return b;
  endfunction

  task automatic write_entry(input int a, input logic [EW-1:0] e, input bit take);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = e;
    tick();
    wr_en = 1'b0;
    if (take) model_mem[a] = e;
  endtask

  task automatic load_random(input int n);
    for (int i = 0; i < n; i++) begin
      logic v, l;
      v = ($urandom_range(0, 3) != 0);
      l = v && ($urandom_range(0, 2) == 0);
      write_entry(i, make_entry(v, l), 1'b1);
    end
  endtask

  // Expected stream: every valid entry of the table, in order, once per pass.
  task automatic push_expected(input int len, input int passes, output int eb, output int ep);
    eb = 0;
    ep = 0;
    for (int p = 0; p < passes; p++) begin
      for (int i = 0; i < len; i++) begin
        if (model_mem[i][4]) begin
          exp_q.push_back(to_beat(model_mem[i]));
          eb++;
          if (model_mem[i][0]) ep++;
        end
      end
    end
  endtask

  task automatic start_run(input int len, input int passes, input bit with_stop, output int n);
    cfg_len    = (AW+1)'(len);
    cfg_passes = 16'(passes);
    start      = 1'b1;
    stop       = with_stop;
    n          = cyc;
    tick();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget, output int dc);
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done required done within %0d cycles", nm, budget);
    end
  endtask

  task automatic run_case(input string nm, input int len, input int passes,
                          input bit with_stop, input bit timed);
    int n, dc, eb, ep;
    push_expected(len, passes, eb, ep);
    done_cnt  = 0;
    acc_cnt   = 0;
    first_acc = -1;
    start_run(len, passes, with_stop, n);
    @(negedge clk);
    check({nm, "_busy"}, busy, 1);
    wait_done(nm, 600, dc);
    if (timed) begin
      check({nm, "_done_cyc"}, dc - n, len * passes + 2);
      if (model_mem[0][4]) check({nm, "_first_beat"}, first_acc - n, 1);
    end
    check({nm, "_beat_cnt"}, beat_cnt, eb);
    check({nm, "_pkt_cnt"}, pkt_cnt, ep);
    check({nm, "_leftover"}, exp_q.size(), 0);
    tick();
    @(negedge clk);
    check({nm, "_done_pulses"}, done_cnt, 1);
    check({nm, "_idle"}, busy, 0);
    exp_q.delete();
  endtask

  initial begin
    int  n, dc, eb, ep;
    bit  seen;

    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_beat_cnt", beat_cnt, 0);
    check("rst_pkt_cnt", pkt_cnt, 0);

    // three beats, last on the third, then a gap entry
    write_entry(0, make_entry(1'b1, 1'b0), 1'b1);
    write_entry(1, make_entry(1'b1, 1'b0), 1'b1);
    write_entry(2, make_entry(1'b1, 1'b1), 1'b1);
    write_entry(3, make_entry(1'b0, 1'b0), 1'b1);
    run_case("basic", 4, 1, 1'b0, 1'b1);
    ready_mode = 1;
    run_case("bp_basic", 4, 1, 1'b0, 1'b0);

    // two-entry pass looped three times; stop in the start cycle must be dropped
    write_entry(0, make_entry(1'b1, 1'b0), 1'b1);
    write_entry(1, make_entry(1'b1, 1'b1), 1'b1);
    ready_mode = 0;
    tick(2);
    run_case("wrap3", 2, 3, 1'b1, 1'b1);
    write_entry(0, make_entry(1'b1, 1'b1), 1'b1);
    run_case("len1", 1, 2, 1'b0, 1'b1);
    load_random(DP);
    run_case("full_depth", DP, 2, 1'b0, 1'b1);

    ready_mode = 1;
    for (int it = 0; it < 6; it++) begin
      int len, passes;
      len    = $urandom_range(1, DP);
      passes = $urandom_range(1, 3);
      load_random(len);
      run_case("rand", len, passes, 1'b0, 1'b0);
    end

    stop = 1'b1;
    tick();
    stop = 1'b0;
    @(negedge clk);
    check("idle_stop_busy", busy, 0);
    check("idle_stop_done", done, 0);

    // infinite passes of two 4-beat packets, stopped at a random point
    for (int i = 0; i < 8; i++) write_entry(i, make_entry(1'b1, (i % 4) == 3), 1'b1);
    for (int p = 0; p < 20; p++)
      for (int i = 0; i < 8; i++) exp_q.push_back(to_beat(model_mem[i]));
    acc_cnt = 0;
    stopped = 0;
    start_run(8, 0, 1'b0, n);
    tick($urandom_range(6, 20));
    stop     = 1'b1;
    stop_cyc = cyc;
    tick();
    stop = 1'b0;
    wait_done("stop_run", 300, dc);
    check("stop_tlast_seen", stopped, 1);
    check("stop_whole_pkts", acc_cnt % 4, 0);
    check("stop_pkt_cnt", pkt_cnt, acc_cnt / 4);
    check("stop_beat_cnt", beat_cnt, acc_cnt);
    exp_q.delete();
    stop_cyc = -1;
    stopped  = 0;
    tick(2);

    start_run(0, 1, 1'b0, n);
    @(negedge clk);
    check("len0_done", done, 1);
    check("len0_tvalid", m_tvalid, 0);
    check("len0_beat_cnt", beat_cnt, 0);
    check("len0_pkt_cnt", pkt_cnt, 0);
    tick();
    @(negedge clk);
    check("len0_done_drop", done, 0);

    // writes issued mid-run must not reach the table
    ready_mode = 0;
    tick(2);
    load_random(4);
    push_expected(4, 2, eb, ep);
    start_run(4, 2, 1'b0, n);
    write_entry(1, make_entry(1'b1, 1'b1), 1'b0);
    write_entry(2, make_entry(1'b1, 1'b0), 1'b0);
    wait_done("wr_busy_run", 200, dc);
    check("wr_busy_beat_cnt", beat_cnt, eb);
    check("wr_busy_leftover", exp_q.size(), 0);
    exp_q.delete();
    tick();
    run_case("wr_busy_replay", 4, 1, 1'b0, 1'b1);
    write_entry(0, make_entry(1'b1, 1'b0), 1'b1);
    run_case("wr_then_start", 4, 1, 1'b0, 1'b1);

    // reset while a beat is stalled on the bus
    ready_mode = 2;
    tick(2);
    start_run(4, 1, 1'b0, n);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      seen = m_tvalid;
    end
    check("rst_mid_pre_valid", seen, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_tvalid", m_tvalid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_beat_cnt", beat_cnt, 0);
    ready_mode = 0;
    tick(2);
    run_case("replay_after_rst", 4, 1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
